// File: rtl/sd_spi_pkg.sv
// sd_spi_pkg: SPI/SD state encoding and fill byte shared by the master and the SD benches
package sd_spi_pkg;
  typedef enum logic [1:0] {IDLE, LOW, HIGH, FIN} spi_state_t;
  localparam logic [7:0] FILL_BYTE = 8'hFF;
endpackage

// File: rtl/spi_sd_master_if.sv
// spi_sd_master_if: host handshake plus SPI pins of the SD-card SPI master
interface spi_sd_master_if;
  logic       start, fast, cs_req, busy, rx_valid, done, sck, mosi, miso, ss;
  logic [7:0] tx_data, rx_data;
  logic [9:0] len;
  modport master (
    input  start, tx_data, len, fast, cs_req, miso,
    output busy, rx_valid, rx_data, done, sck, mosi, ss
  );
  modport slave (
    output start, tx_data, len, fast, cs_req, miso,
    input  busy, rx_valid, rx_data, done, sck, mosi, ss
  );
endinterface

// File: rtl/spi_clk_div.sv
// spi_clk_div: half-period down-counter; tc_o flags the last cycle of a phase
module spi_clk_div #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] div_i,
  output logic         tc_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk)
    cnt_q <= rst ? '0 : load_i ? div_i : (cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
  assign tc_o = cnt_q == '0;
endmodule

// File: rtl/spi_sd_master.sv
// spi_sd_master: mode-0 SPI master for SD cards with selectable init/fast SCK rate
module spi_sd_master import sd_spi_pkg::*; #(
  parameter int SLOW_DIV = 63,
  parameter int FAST_DIV = 1
) (
  input logic             clk_sys,
  input logic             reset,
  spi_sd_master_if.master bus
);
  localparam int DMAX = SLOW_DIV > FAST_DIV ? SLOW_DIV : FAST_DIV;
  localparam int DW   = DMAX < 1 ? 1 : $clog2(DMAX + 1);
  spi_state_t state_q, state_d;
  logic [7:0] tx_q, tx_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
  logic [9:0] rem_q, rem_d;
  logic [2:0] bit_q, bit_d;
  logic fast_q, fast_d, sck_q, sck_d, busy_q, busy_d;
  logic rx_valid_q, rx_valid_d, done_q, done_d, load, tc;
  logic [DW-1:0] div_val;
  // the divider is loaded at accept, before fast has been latched
  assign div_val = ((state_q == IDLE) ? bus.fast : fast_q) ? DW'(FAST_DIV) : DW'(SLOW_DIV);
  spi_clk_div #(.W(DW)) u_div (
    .clk(clk_sys), .rst(reset), .load_i(load), .div_i(div_val), .tc_o(tc)
  );
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= IDLE;
      tx_q       <= FILL_BYTE;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rem_q      <= '0;
      bit_q      <= '0;
      fast_q     <= 1'b0;
      sck_q      <= 1'b0;
      busy_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rem_q      <= rem_d;
      bit_q      <= bit_d;
      fast_q     <= fast_d;
      sck_q      <= sck_d;
      busy_q     <= busy_d;
      rx_valid_q <= rx_valid_d;
      done_q     <= done_d;
    end
  end
  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rem_d      = rem_q;
    bit_d      = bit_q;
    fast_d     = fast_q;
    sck_d      = sck_q;
    busy_d     = busy_q;
    rx_valid_d = 1'b0;
    done_d     = 1'b0;
    load       = 1'b0;
    case (state_q)
      IDLE: begin
        // busy spans the done cycle, so a start seen alongside done is not taken
        if (done_q) busy_d = 1'b0;
        else if (bus.start && !busy_q) begin
          tx_d    = bus.tx_data;
          rem_d   = bus.len;
          fast_d  = bus.fast;
          bit_d   = '0;
          busy_d  = 1'b1;
          load    = 1'b1;
          state_d = LOW;
        end
      end
      LOW: if (tc) begin
        state_d = HIGH;
        sck_d   = 1'b1;
        rx_sh_d = {rx_sh_q[6:0], bus.miso};
        load    = 1'b1;
      end
      HIGH: if (tc) begin
        sck_d   = 1'b0;
        tx_d    = {tx_q[6:0], 1'b1};
        bit_d   = bit_q + 3'd1;
        state_d = LOW;
        load    = 1'b1;
        if (bit_q == 3'd7) begin
          rx_data_d  = rx_sh_q;
          rx_valid_d = 1'b1;
          if (rem_q != '0) begin
            rem_d = rem_q - 10'd1;
            tx_d  = FILL_BYTE;
          end else begin
            state_d = FIN;
            load    = 1'b0;
          end
        end
      end
      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign bus.busy     = busy_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.done     = done_q;
  assign bus.sck      = sck_q;
  assign bus.mosi     = tx_q[7];
  assign bus.ss       = ~(bus.cs_req | (busy_q & ~reset));
endmodule

// File: tb/tb_spi_sd_master.sv
// tb_spi_sd_master: directed checks of the SD SPI master against a behavioural SPI slave
module tb_spi_sd_master;
  localparam int SLOW = 63;
  localparam int FAST = 1;
  localparam int FB   = 16 * (FAST + 1);
  localparam int SB   = 16 * (SLOW + 1);
  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  spi_sd_master_if sif();
  spi_sd_master #(.SLOW_DIV(SLOW), .FAST_DIV(FAST)) dut (
    .clk_sys(clk_sys), .reset(reset), .bus(sif)
  );
  always #5 clk_sys = ~clk_sys;
  int checks = 0;
  int failures = 0;
  logic [7:0] resp [0:3];
  int sbits = 0;
  int sbase = 0;
  int mosi_n = 0;
  int mb0 = 0;
  int rel;
  logic [31:0] mosi_sh = '0;
  always @(negedge sif.sck) sbits++;
  always @(posedge sif.sck) begin
    mosi_sh = {mosi_sh[30:0], sif.mosi};
    mosi_n++;
  end
  assign rel = sbits - sbase;
  assign sif.miso = (rel >= 0 && rel < 32) ? resp[rel[4:3]][3'd7 - rel[2:0]] : 1'b1;

  task automatic start_xfer(input logic [7:0] d, input logic [9:0] l, input logic f);
    sif.tx_data = d;
    sif.len     = l;
    sif.fast    = f;
    sif.start   = 1'b1;
    sbase       = sbits;
    mb0         = mosi_n;
    @(posedge clk_sys); #1;
    sif.start = 1'b0;
  endtask

  task automatic test_reset;
    sif.start = 1'b0; sif.cs_req = 1'b0; sif.fast = 1'b1; sif.tx_data = '0; sif.len = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk_sys);
    #1;
    checks++; if (sif.sck !== 1'b0) begin failures++; $display("FAIL reset_sck got=%b exp=0", sif.sck); end
    checks++; if (sif.mosi !== 1'b1) begin failures++; $display("FAIL reset_mosi got=%b exp=1", sif.mosi); end
    checks++; if (sif.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", sif.busy); end
    checks++; if (sif.rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got=%b exp=0", sif.rx_valid); end
    checks++; if (sif.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", sif.done); end
    checks++; if (sif.rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx_data got=%h exp=00", sif.rx_data); end
    checks++; if (sif.ss !== 1'b1) begin failures++; $display("FAIL reset_ss_idle got=%b exp=1", sif.ss); end
    sif.cs_req = 1'b1;
    #1;
    checks++; if (sif.ss !== 1'b0) begin failures++; $display("FAIL reset_ss_csreq got=%b exp=0", sif.ss); end
    sif.cs_req = 1'b0;
    reset = 1'b0;
    @(posedge clk_sys); #1;
  endtask

  task automatic test_single;
    int dn = -1, rv = 0;
    resp[0] = 8'h3C;
    start_xfer(8'hA5, 10'd0, 1'b1);
    checks++; if (sif.busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", sif.busy); end
    for (int n = 1; n <= FB + 8 && dn < 0; n++) begin
      @(posedge clk_sys); #1;
      if (sif.rx_valid) rv++;
      if (sif.done) dn = n;
    end
    checks++; if (dn !== FB + 1) begin failures++; $display("FAIL single_done_cycle got=%0d exp=%0d", dn, FB + 1); end
    checks++; if (rv !== 1) begin failures++; $display("FAIL single_rx_valid_count got=%0d exp=1", rv); end
    checks++; if (sif.rx_data !== 8'h3C) begin failures++; $display("FAIL single_rx_data got=%h exp=3c", sif.rx_data); end
    checks++; if (mosi_sh[7:0] !== 8'hA5) begin failures++; $display("FAIL single_mosi got=%h exp=a5", mosi_sh[7:0]); end
    checks++; if (mosi_n - mb0 !== 8) begin failures++; $display("FAIL single_sck_edges got=%0d exp=8", mosi_n - mb0); end
    @(posedge clk_sys); #1;
    checks++; if (sif.done !== 1'b0) begin failures++; $display("FAIL single_done_width got=%b exp=0", sif.done); end
    checks++; if (sif.busy !== 1'b0) begin failures++; $display("FAIL single_busy_end got=%b exp=0", sif.busy); end
  endtask

  task automatic test_burst;
    int rvc [4];
    logic [7:0] rxb [4];
    int rv = 0, dn = -1;
    resp[0] = 8'h00; resp[1] = 8'hFE; resp[2] = 8'h12; resp[3] = 8'h34;
    start_xfer(8'h51, 10'd3, 1'b1);
    for (int n = 1; n <= 4 * FB + 8 && dn < 0; n++) begin
      @(posedge clk_sys); #1;
      if (sif.rx_valid) begin
        if (rv < 4) begin rvc[rv] = n; rxb[rv] = sif.rx_data; end
        rv++;
      end
      if (sif.done) dn = n;
    end
    checks++; if (rv !== 4) begin failures++; $display("FAIL burst_rx_count got=%0d exp=4", rv); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (rvc[k] !== FB * (k + 1)) begin failures++; $display("FAIL burst_strobe_cycle[%0d] got=%0d exp=%0d", k, rvc[k], FB * (k + 1)); end
      checks++; if (rxb[k] !== resp[k]) begin failures++; $display("FAIL burst_rx_data[%0d] got=%h exp=%h", k, rxb[k], resp[k]); end
    end
    checks++; if (dn !== 4 * FB + 1) begin failures++; $display("FAIL burst_done_cycle got=%0d exp=%0d", dn, 4 * FB + 1); end
    checks++; if (mosi_sh !== 32'h51FFFFFF) begin failures++; $display("FAIL burst_mosi got=%h exp=51ffffff", mosi_sh); end
    @(posedge clk_sys); #1;
  endtask

  task automatic test_slow;
    int dn = -1, rvn = -1, rises = 0, hi_bad = 0, lo_bad = 0;
    int first_rise = -1, last_rise = 0, last_fall = 0;
    logic prev = 1'b0;
    resp[0] = 8'h96;
    start_xfer(8'h3C, 10'd0, 1'b0);
    for (int n = 1; n <= SB + 8 && dn < 0; n++) begin
      @(posedge clk_sys); #1;
      if (sif.sck && !prev) begin
        if (first_rise < 0) first_rise = n;
        else if (n - last_fall != SLOW + 1) lo_bad++;
        last_rise = n;
        rises++;
      end
      if (!sif.sck && prev) begin
        if (n - last_rise != SLOW + 1) hi_bad++;
        last_fall = n;
      end
      prev = sif.sck;
      if (sif.rx_valid) rvn = n;
      if (sif.done) dn = n;
    end
    checks++; if (first_rise !== SLOW + 1) begin failures++; $display("FAIL slow_first_low got=%0d exp=%0d", first_rise, SLOW + 1); end
    checks++; if (rises !== 8) begin failures++; $display("FAIL slow_rises got=%0d exp=8", rises); end
    checks++; if (hi_bad !== 0) begin failures++; $display("FAIL slow_high_len bad=%0d exp=0", hi_bad); end
    checks++; if (lo_bad !== 0) begin failures++; $display("FAIL slow_low_len bad=%0d exp=0", lo_bad); end
    checks++; if (rvn !== SB) begin failures++; $display("FAIL slow_byte_len got=%0d exp=%0d", rvn, SB); end
    checks++; if (dn !== SB + 1) begin failures++; $display("FAIL slow_done_cycle got=%0d exp=%0d", dn, SB + 1); end
    checks++; if (sif.rx_data !== 8'h96) begin failures++; $display("FAIL slow_rx_data got=%h exp=96", sif.rx_data); end
    checks++; if (mosi_sh[7:0] !== 8'h3C) begin failures++; $display("FAIL slow_mosi got=%h exp=3c", mosi_sh[7:0]); end
    @(posedge clk_sys); #1;
  endtask

  task automatic test_cs_hold;
    int dn = -1, bad = 0;
    logic ss_done = 1'bx;
    resp[0] = 8'hE1;
    sif.cs_req = 1'b1;
    start_xfer(8'h5A, 10'd0, 1'b1);
    for (int n = 0; n < 2 * FB && rel < 3; n++) begin
      @(posedge clk_sys); #1;
    end
    checks++; if (rel !== 3) begin failures++; $display("FAIL cs_reach_bit3 got=%0d exp=3", rel); end
    sif.cs_req = 1'b0;
    for (int n = 0; n <= FB + 8 && dn < 0; n++) begin
      @(posedge clk_sys); #1;
      if (sif.done) begin dn = n; ss_done = sif.ss; end
      else if (sif.ss !== 1'b0) bad++;
    end
    checks++; if (dn < 0) begin failures++; $display("FAIL cs_done_seen got=%0d exp=done", dn); end
    checks++; if (bad !== 0) begin failures++; $display("FAIL cs_ss_held bad=%0d exp=0", bad); end
    checks++; if (ss_done !== 1'b0) begin failures++; $display("FAIL cs_ss_at_done got=%b exp=0", ss_done); end
    @(posedge clk_sys); #1;
    checks++; if (sif.ss !== 1'b1) begin failures++; $display("FAIL cs_ss_after_done got=%b exp=1", sif.ss); end
  endtask

  task automatic test_reset_mid;
    int rv = 0, dn = 0, bz = 0;
    resp[0] = 8'h77;
    start_xfer(8'h00, 10'd0, 1'b1);
    for (int n = 0; n < 2 * FB && !(rel == 5 && sif.sck); n++) begin
      @(posedge clk_sys); #1;
    end
    checks++; if (!(rel == 5 && sif.sck === 1'b1)) begin failures++; $display("FAIL rstmid_reach_bit5 got=%0d exp=5", rel); end
    reset = 1'b1;
    #1;
    checks++; if (sif.ss !== 1'b1) begin failures++; $display("FAIL rstmid_ss_in_reset got=%b exp=1", sif.ss); end
    @(posedge clk_sys); #1;
    checks++; if (sif.sck !== 1'b0) begin failures++; $display("FAIL rstmid_sck got=%b exp=0", sif.sck); end
    checks++; if (sif.mosi !== 1'b1) begin failures++; $display("FAIL rstmid_mosi got=%b exp=1", sif.mosi); end
    checks++; if (sif.busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", sif.busy); end
    checks++; if (sif.rx_data !== 8'h00) begin failures++; $display("FAIL rstmid_rx_data got=%h exp=00", sif.rx_data); end
    reset = 1'b0;
    for (int n = 0; n < 2 * FB; n++) begin
      if (sif.rx_valid) rv++;
      if (sif.done) dn++;
      if (sif.busy) bz++;
      @(posedge clk_sys); #1;
    end
    checks++; if (rv !== 0) begin failures++; $display("FAIL rstmid_rx_valid got=%0d exp=0", rv); end
    checks++; if (dn !== 0) begin failures++; $display("FAIL rstmid_done got=%0d exp=0", dn); end
    checks++; if (bz !== 0) begin failures++; $display("FAIL rstmid_busy_after got=%0d exp=0", bz); end
  endtask

  task automatic test_back_to_back;
    int dn = -1, dn2 = -1;
    resp[0] = 8'h5C;
    sif.tx_data = 8'hC6; sif.len = 10'd0; sif.fast = 1'b1; sif.start = 1'b1;
    sbase = sbits; mb0 = mosi_n;
    @(posedge clk_sys); #1;
    sif.tx_data = 8'h00; sif.len = 10'h3FF; sif.fast = 1'b0;
    for (int n = 1; n <= FB + 8 && dn < 0; n++) begin
      @(posedge clk_sys); #1;
      if (sif.done) dn = n;
    end
    checks++; if (dn !== FB + 1) begin failures++; $display("FAIL b2b_first_done got=%0d exp=%0d", dn, FB + 1); end
    checks++; if (mosi_sh[7:0] !== 8'hC6) begin failures++; $display("FAIL b2b_first_mosi got=%h exp=c6", mosi_sh[7:0]); end
    checks++; if (sif.rx_data !== 8'h5C) begin failures++; $display("FAIL b2b_first_rx got=%h exp=5c", sif.rx_data); end
    sif.tx_data = 8'h96; sif.len = 10'd0; sif.fast = 1'b1;
    resp[0] = 8'h2B;
    sbase = sbits; mb0 = mosi_n;
    @(posedge clk_sys); #1;
    checks++; if (sif.busy !== 1'b0) begin failures++; $display("FAIL b2b_start_at_done_ignored got=%b exp=0", sif.busy); end
    @(posedge clk_sys); #1;
    checks++; if (sif.busy !== 1'b1) begin failures++; $display("FAIL b2b_second_accept got=%b exp=1", sif.busy); end
    sif.start = 1'b0;
    for (int n = 1; n <= FB + 8 && dn2 < 0; n++) begin
      @(posedge clk_sys); #1;
      if (sif.done) dn2 = n;
    end
    checks++; if (dn2 !== FB + 1) begin failures++; $display("FAIL b2b_second_done got=%0d exp=%0d", dn2, FB + 1); end
    checks++; if (mosi_sh[7:0] !== 8'h96) begin failures++; $display("FAIL b2b_second_mosi got=%h exp=96", mosi_sh[7:0]); end
    checks++; if (sif.rx_data !== 8'h2B) begin failures++; $display("FAIL b2b_second_rx got=%h exp=2b", sif.rx_data); end
    checks++; if (mosi_n - mb0 !== 8) begin failures++; $display("FAIL b2b_second_edges got=%0d exp=8", mosi_n - mb0); end
  endtask

  initial begin
    resp[0] = 8'hFF; resp[1] = 8'hFF; resp[2] = 8'hFF; resp[3] = 8'hFF;
    test_reset();
    test_single();
    test_burst();
    test_slow();
    test_cs_hold();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
